jtagreg_seq: RTL and testbench



---
 rtl/jtagreg_seq_pkg.sv | 14 +
 rtl/jtagreg_seq_tick.sv | 27 ++
 rtl/jtagreg_seq.sv | 142 ++++++++++++++
 tb/tb_jtagreg_seq.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/jtagreg_seq_pkg.sv
// Shared types and defaults for the scan-chain sequencer.
package jtagreg_seq_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CAPTURE = 3'd1,
    SHIFT   = 3'd2,
    UPDATE  = 3'd3,
    RESP    = 3'd4
  } state_e;

  localparam int unsigned MIN_DIV_DEF = 3;

endpackage

// File: rtl/jtagreg_seq_tick.sv
// Loadable down-counter; tick is high while running and the count reads zero.
module jtagreg_seq_tick #(
  parameter int unsigned DIVW = 8
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            load_i,
  input  logic [DIVW-1:0] value_i,
  input  logic            run_i,
  output logic            tick_o
);

  logic [DIVW-1:0] r_cnt;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_cnt <= '0;
    end else if (load_i) begin
      r_cnt <= value_i;
    end else if (run_i && (r_cnt != '0)) begin
      r_cnt <= r_cnt - DIVW'(1);
    end
  end

  assign tick_o = run_i && (r_cnt == '0);

endmodule

// File: rtl/jtagreg_seq.sv
// Sequences capture/shift/update strobes and paced enable pulses for a scan
// data register chain, serialising write data and collecting captured bits.
module jtagreg_seq
  import jtagreg_seq_pkg::*;
#(
  parameter int unsigned REGSIZE = 96,
  parameter int unsigned CNTW    = $clog2(REGSIZE + 1),
  parameter int unsigned DIVW    = 8,
  parameter int unsigned MIN_DIV = MIN_DIV_DEF
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [DIVW-1:0]    cfg_div_i,
  input  logic               req_valid_i,
  output logic               req_ready_o,
  input  logic [REGSIZE-1:0] req_wdata_i,
  input  logic [CNTW-1:0]    req_len_i,
  input  logic               req_capture_i,
  input  logic               req_update_i,
  input  logic               abort_i,
  output logic               rsp_valid_o,
  input  logic               rsp_ready_i,
  output logic [REGSIZE-1:0] rsp_rdata_o,
  output logic               enable_o,
  output logic               capture_dr_o,
  output logic               shift_dr_o,
  output logic               update_dr_o,
  output logic               scan_out_o,
  input  logic               scan_in_i,
  output logic               busy_o
);

  localparam int unsigned IDXW = $clog2(REGSIZE);

  state_e               r_state;
  state_e               w_next;
  logic [REGSIZE-1:0]   r_wdata;
  logic [REGSIZE-1:0]   r_rdata;
  logic [CNTW-1:0]      r_len;
  logic [CNTW-1:0]      r_bitcnt;
  logic [DIVW-1:0]      r_div;
  logic                 r_upd;

  logic                 w_accept;
  logic                 w_tick;
  logic                 w_run;
  logic                 w_last;
  logic [DIVW-1:0]      w_div_clamped;
  logic [CNTW-1:0]      w_len_eff;

  // Divider floor keeps each period long enough for the chain's synchroniser.
  assign w_div_clamped = (cfg_div_i < DIVW'(MIN_DIV)) ? DIVW'(MIN_DIV) : cfg_div_i;
  assign w_len_eff     = ((req_len_i == '0) || (req_len_i > CNTW'(REGSIZE)))
                         ? CNTW'(REGSIZE) : req_len_i;

  assign req_ready_o = (r_state == IDLE) && !rst_i;
  assign w_accept    = req_ready_o && req_valid_i;
  assign w_run       = (r_state == CAPTURE) || (r_state == SHIFT) || (r_state == UPDATE);
  assign w_last      = (r_bitcnt == (r_len - CNTW'(1)));
  assign rsp_rdata_o = r_rdata;
  assign enable_o    = w_tick;

  jtagreg_seq_tick #(
    .DIVW (DIVW)
  ) u_tick (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .load_i  (w_accept || w_tick),
    .value_i (w_accept ? w_div_clamped : r_div),
    .run_i   (w_run),
    .tick_o  (w_tick)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next       = r_state;
    capture_dr_o = 1'b0;
    shift_dr_o   = 1'b0;
    update_dr_o  = 1'b0;
    scan_out_o   = 1'b0;
    rsp_valid_o  = 1'b0;
    busy_o       = (r_state != IDLE);
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_next = req_capture_i ? CAPTURE : SHIFT;
        end
      end
      CAPTURE: begin
        capture_dr_o = 1'b1;
        if (abort_i)     w_next = IDLE;
        else if (w_tick) w_next = SHIFT;
      end
      SHIFT: begin
        shift_dr_o = 1'b1;
        scan_out_o = r_wdata[IDXW'(r_bitcnt)];
        if (abort_i)                w_next = IDLE;
        else if (w_tick && w_last)  w_next = r_upd ? UPDATE : RESP;
      end
      UPDATE: begin
        update_dr_o = 1'b1;
        if (abort_i)     w_next = IDLE;
        else if (w_tick) w_next = RESP;
      end
      RESP: begin
        rsp_valid_o = 1'b1;
        if (rsp_ready_i) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // Captured bit is the chain output present on the enable cycle, before it shifts.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wdata  <= '0;
      r_rdata  <= '0;
      r_len    <= '0;
      r_bitcnt <= '0;
      r_div    <= '0;
      r_upd    <= 1'b0;
    end else if (w_accept) begin
      r_wdata  <= req_wdata_i;
      r_rdata  <= '0;
      r_len    <= w_len_eff;
      r_bitcnt <= '0;
      r_div    <= w_div_clamped;
      r_upd    <= req_update_i;
    end else if ((r_state == SHIFT) && w_tick) begin
      r_rdata[IDXW'(r_bitcnt)] <= scan_in_i;
      r_bitcnt                 <= r_bitcnt + CNTW'(1);
    end
  end

endmodule

// File: tb/tb_jtagreg_seq.sv
// Directed bench: per-cycle transaction model plus an 8-bit behavioural chain.
module tb_jtagreg_seq;

  localparam int unsigned REGSIZE = 96;
  localparam int unsigned CNTW    = 7;
  localparam int unsigned DIVW    = 8;
  localparam int unsigned L       = 8;

  logic               clk_i = 1'b0;
  logic               rst_i = 1'b0;
  logic [DIVW-1:0]    cfg_div_i = '0;
  logic               req_valid_i = 1'b0;
  logic               req_ready_o;
  logic [REGSIZE-1:0] req_wdata_i = '0;
  logic [CNTW-1:0]    req_len_i = '0;
  logic               req_capture_i = 1'b0;
  logic               req_update_i = 1'b0;
  logic               abort_i = 1'b0;
  logic               rsp_valid_o;
  logic               rsp_ready_i = 1'b0;
  logic [REGSIZE-1:0] rsp_rdata_o;
  logic               enable_o;
  logic               capture_dr_o;
  logic               shift_dr_o;
  logic               update_dr_o;
  logic               scan_out_o;
  logic               scan_in_i;
  logic               busy_o;

  always #5 clk_i = ~clk_i;

  jtagreg_seq dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .cfg_div_i     (cfg_div_i),
    .req_valid_i   (req_valid_i),
    .req_ready_o   (req_ready_o),
    .req_wdata_i   (req_wdata_i),
    .req_len_i     (req_len_i),
    .req_capture_i (req_capture_i),
    .req_update_i  (req_update_i),
    .abort_i       (abort_i),
    .rsp_valid_o   (rsp_valid_o),
    .rsp_ready_i   (rsp_ready_i),
    .rsp_rdata_o   (rsp_rdata_o),
    .enable_o      (enable_o),
    .capture_dr_o  (capture_dr_o),
    .shift_dr_o    (shift_dr_o),
    .update_dr_o   (update_dr_o),
    .scan_out_o    (scan_out_o),
    .scan_in_i     (scan_in_i),
    .busy_o        (busy_o)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [REGSIZE-1:0] act, input logic [REGSIZE-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Behavioural 8-cell chain with parallel input fixed at 0x3C.
  localparam logic [L-1:0] CH_IN = 8'h3C;
  logic [L-1:0] ch_sh  = '0;
  logic [L-1:0] ch_par = '0;
  assign scan_in_i = ch_sh[0];

  always @(posedge clk_i) begin
    if (enable_o) begin
      if (capture_dr_o)     ch_sh  <= CH_IN;
      else if (shift_dr_o)  ch_sh  <= {scan_out_o, ch_sh[L-1:1]};
      else if (update_dr_o) ch_par <= ch_sh;
    end
  end

  // Transaction model: expected per-cycle phase/enable/bit list built at accept.
  typedef struct packed {
    logic [1:0] code;
    logic       en;
    logic [6:0] bitn;
  } ent_t;

  ent_t               q[$];
  ent_t               e;
  int                 mode = 0;
  logic [REGSIZE-1:0] m_wdata = '0;
  logic [REGSIZE-1:0] m_rdata = '0;
  logic [7:0]         exp_v;
  logic [7:0]         act_v;
  int                 de, p, le;
  int                 cnt_cap = 0, cnt_shift = 0, cnt_upd = 0, cnt_en = 0, cnt_rsp = 0;

  always begin
    @(negedge clk_i);
    act_v = {req_ready_o, busy_o, rsp_valid_o, enable_o,
             capture_dr_o, shift_dr_o, update_dr_o, scan_out_o};
    if (capture_dr_o) cnt_cap++;
    if (shift_dr_o)   cnt_shift++;
    if (update_dr_o)  cnt_upd++;
    if (enable_o)     cnt_en++;
    if (rsp_valid_o)  cnt_rsp++;
    exp_v = 8'h00;
    if (rst_i) begin
      mode = 0;
      q.delete();
    end else begin
      case (mode)
        0: exp_v = 8'b1000_0000;
        1: begin
          e = q[0];
          exp_v = {1'b0, 1'b1, 1'b0, e.en, e.code == 2'd1, e.code == 2'd2, e.code == 2'd3,
                   (e.code == 2'd2) ? m_wdata[e.bitn] : 1'b0};
          if (e.en && (e.code == 2'd2)) m_rdata[e.bitn] = ch_sh[0];
        end
        default: begin
          exp_v = 8'b0110_0000;
          chk("rsp_rdata", rsp_rdata_o, m_rdata);
        end
      endcase
    end
    chk("outputs{rdy,busy,rvld,en,cap,sh,upd,so}", REGSIZE'(act_v), REGSIZE'(exp_v));
    @(posedge clk_i);
    if (!rst_i) begin
      case (mode)
        0: if (req_valid_i) begin
          de = (cfg_div_i < 8'd3) ? 3 : int'(cfg_div_i);
          p  = de + 1;
          le = ((req_len_i == 7'd0) || (req_len_i > 7'd96)) ? 96 : int'(req_len_i);
          q.delete();
          if (req_capture_i)
            for (int k = 0; k < p; k++) q.push_back('{code: 2'd1, en: (k == p - 1), bitn: 7'd0});
          for (int b = 0; b < le; b++)
            for (int k = 0; k < p; k++) q.push_back('{code: 2'd2, en: (k == p - 1), bitn: 7'(b)});
          if (req_update_i)
            for (int k = 0; k < p; k++) q.push_back('{code: 2'd3, en: (k == p - 1), bitn: 7'd0});
          m_wdata = req_wdata_i;
          m_rdata = '0;
          cnt_cap = 0; cnt_shift = 0; cnt_upd = 0; cnt_en = 0; cnt_rsp = 0;
          mode = 1;
        end
        1: begin
          if (abort_i) begin
            q.delete();
            mode = 0;
          end else begin
            void'(q.pop_front());
            if (q.size() == 0) mode = 2;
          end
        end
        default: if (rsp_ready_i) mode = 0;
      endcase
    end
  end

  task automatic send_req(input logic [7:0] div, input logic [6:0] len, input logic [95:0] wd,
                          input logic cap, input logic upd);
    int g;
    @(posedge clk_i); #1;
    cfg_div_i = div; req_len_i = len; req_wdata_i = wd;
    req_capture_i = cap; req_update_i = upd; req_valid_i = 1'b1;
    g = 0;
    do begin
      @(negedge clk_i);
      g++;
    end while (!req_ready_o && g < 50);
    chk("req_ready_at_accept", REGSIZE'(req_ready_o), REGSIZE'(1));
    @(posedge clk_i); #1;
    req_valid_i = 1'b0;
  endtask

  task automatic wait_rsp(input int hold, output logic [95:0] rd);
    int g;
    g = 0;
    do begin
      @(negedge clk_i);
      g++;
    end while (!rsp_valid_o && g < 5000);
    chk("rsp_valid_seen", REGSIZE'(rsp_valid_o), REGSIZE'(1));
    rd = rsp_rdata_o;
    repeat (hold) @(negedge clk_i);
    #1 rsp_ready_i = 1'b1;
    @(posedge clk_i); #1;
    rsp_ready_i = 1'b0;
  endtask

  logic [95:0] rd;
  logic [95:0] w4;
  int          ens, g;

  initial begin
    #1 rst_i = 1'b1;
    repeat (3) @(posedge clk_i);
    #2;
    chk("reset_outputs", REGSIZE'({req_ready_o, busy_o, rsp_valid_o, enable_o, capture_dr_o,
                                    shift_dr_o, update_dr_o, scan_out_o}), '0);
    chk("reset_rdata", rsp_rdata_o, '0);
    @(posedge clk_i); #1 rst_i = 1'b0;

    // Full capture/shift/update of the 8-bit chain.
    send_req(8'd3, 7'd8, 96'hA5, 1'b1, 1'b1);
    wait_rsp(0, rd);
    chk("t1_rdata", rd, 96'h3C);
    chk("t1_par_out", REGSIZE'(ch_par), 96'hA5);
    chk("t1_cap_cycles", REGSIZE'(cnt_cap), 96'd4);
    chk("t1_shift_cycles", REGSIZE'(cnt_shift), 96'd32);
    chk("t1_upd_cycles", REGSIZE'(cnt_upd), 96'd4);
    chk("t1_enables", REGSIZE'(cnt_en), 96'd10);
    chk("t1_ready_after", REGSIZE'(req_ready_o), 96'd1);

    // Divider 0 clamps to a 4-cycle period; chain still holds 0xA5.
    send_req(8'd0, 7'd4, 96'h9, 1'b0, 1'b0);
    wait_rsp(0, rd);
    chk("t2_rdata", rd, 96'h5);
    chk("t2_shift_cycles", REGSIZE'(cnt_shift), 96'd16);
    chk("t2_enables", REGSIZE'(cnt_en), 96'd4);

    send_req(8'd7, 7'd3, 96'h2, 1'b1, 1'b0);
    wait_rsp(0, rd);
    chk("t3_rdata", rd, 96'h4);
    chk("t3_cap_cycles", REGSIZE'(cnt_cap), 96'd8);
    chk("t3_shift_cycles", REGSIZE'(cnt_shift), 96'd24);
    chk("t3_enables", REGSIZE'(cnt_en), 96'd4);

    // len=0 means full 96 bits; wdata streams back through the 8-bit chain.
    w4 = 96'h0123_4567_89AB_CDEF_FEDC_BA98;
    send_req(8'd3, 7'd0, w4, 1'b1, 1'b0);
    wait_rsp(0, rd);
    chk("t4_rdata", rd, {w4[87:0], 8'h3C});
    chk("t4_enables", REGSIZE'(cnt_en), 96'd97);

    send_req(8'd3, 7'd5, 96'h1F, 1'b1, 1'b1);
    wait_rsp(0, rd);
    chk("t5_rdata", rd, 96'h1C);
    chk("t5_enables", REGSIZE'(cnt_en), 96'd7);

    send_req(8'd3, 7'd100, 96'h0, 1'b0, 1'b0);
    wait_rsp(0, rd);
    chk("t6_len_over_enables", REGSIZE'(cnt_en), 96'd96);

    // Abort on the 3rd shift enable.
    send_req(8'd3, 7'd8, 96'hFF, 1'b1, 1'b1);
    ens = 0;
    g = 0;
    while (ens < 3 && g < 500) begin
      @(negedge clk_i);
      g++;
      if (enable_o && shift_dr_o) ens++;
    end
    chk("abort_third_enable_seen", REGSIZE'(ens), 96'd3);
    #1 abort_i = 1'b1;
    @(posedge clk_i); #1;
    abort_i = 1'b0;
    chk("abort_shift_drop", REGSIZE'(shift_dr_o), 96'd0);
    chk("abort_ready_next", REGSIZE'(req_ready_o), 96'd1);
    repeat (10) @(posedge clk_i);
    #1;
    chk("abort_no_update", REGSIZE'(cnt_upd), 96'd0);
    chk("abort_no_rsp", REGSIZE'(cnt_rsp), 96'd0);
    chk("abort_enables", REGSIZE'(cnt_en), 96'd4);

    // Response back-pressure.
    send_req(8'd3, 7'd4, 96'h6, 1'b0, 1'b0);
    wait_rsp(20, rd);
    chk("hold_rsp_cycles", REGSIZE'(cnt_rsp), 96'd21);
    chk("hold_ready_after", REGSIZE'(req_ready_o), 96'd1);

    // Asynchronous reset mid-shift.
    send_req(8'd3, 7'd8, 96'hA5, 1'b1, 1'b1);
    repeat (10) @(posedge clk_i);
    #3;
    chk("pre_reset_in_shift", REGSIZE'(shift_dr_o), 96'd1);
    rst_i = 1'b1;
    #1;
    chk("async_reset_outputs", REGSIZE'({req_ready_o, busy_o, rsp_valid_o, enable_o, capture_dr_o,
                                          shift_dr_o, update_dr_o, scan_out_o}), '0);
    @(posedge clk_i); #1 rst_i = 1'b0;
    send_req(8'd3, 7'd8, 96'hA5, 1'b1, 1'b1);
    wait_rsp(0, rd);
    chk("post_reset_rdata", rd, 96'h3C);
    chk("post_reset_par_out", REGSIZE'(ch_par), 96'hA5);

    repeat (3) @(posedge clk_i);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
